// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: default widths and the fetch FSM encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF   = 8;
    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned RESET_PC_DEF = 0;

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_ADDR  = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_EXEC  = 3'd4,
        S_HALT  = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/ld_reg.sv
// Load-enable register with a synchronous, active-high reset to a fixed value.
module ld_reg #(
    parameter int unsigned   W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Reset wins over load; otherwise hold unless enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns PC and IR, reads a 1-cycle-latency synchronous RAM and
// hands each instruction to the controller over a valid/ready handshake. While the
// controller executes, the memory address port is lent to the datapath.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              exec_done,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    input  logic              halt,
    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    output logic [ADDR_W-1:0] pc_out
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_d;

    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_d;
    logic              w_pc_en;
    logic [DATA_W-1:0] w_ir;
    logic              w_ir_en;
    logic [ADDR_W-1:0] w_pc_inc;

    // Increment wraps modulo 2^ADDR_W with no flag.
    assign w_pc_inc = w_pc + ADDR_W'(1);

    ld_reg #(
        .W       (ADDR_W),
        .RST_VAL (ADDR_W'(RESET_PC))
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_pc_en),
        .i_d   (w_pc_d),
        .o_q   (w_pc)
    );

    ld_reg #(
        .W       (DATA_W),
        .RST_VAL ('0)
    ) u_ir_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_ir_en),
        .i_d   (mem_rdata),
        .o_q   (w_ir)
    );

    // State register; reset forces S_RST from any state, including mid-fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state, PC/IR load enables and state-decoded outputs.
    always_comb begin
        w_state_d = r_state;
        w_pc_en   = 1'b0;
        w_pc_d    = w_pc;
        w_ir_en   = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = w_pc;
        ir_valid  = 1'b0;

        unique case (r_state)
            S_RST: begin
                w_state_d = S_ADDR;
            end
            S_ADDR: begin
                mem_rd    = 1'b1;
                w_state_d = S_WAIT;
            end
            S_WAIT: begin
                // Read data for pc is on mem_rdata this cycle.
                mem_rd    = 1'b1;
                w_ir_en   = 1'b1;
                w_pc_en   = 1'b1;
                w_pc_d    = w_pc_inc;
                w_state_d = S_VALID;
            end
            S_VALID: begin
                ir_valid = 1'b1;
                if (ir_ready) begin
                    w_state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (data_req) begin
                    mem_addr = data_addr;
                end
                if (exec_done) begin
                    w_pc_en   = 1'b1;
                    w_pc_d    = pc_load ? pc_target : w_pc;
                    w_state_d = halt ? S_HALT : S_ADDR;
                end
            end
            S_HALT: begin
                w_state_d = S_HALT;
            end
            default: begin
                w_state_d = S_RST;
            end
        endcase
    end

    assign ir_out = w_ir;
    assign pc_out = w_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch with a behavioural 1-cycle-latency RAM.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        exec_done;
    logic        pc_load;
    logic [7:0]  pc_target;
    logic        halt;
    logic        data_req;
    logic [7:0]  data_addr;
    logic [7:0]  pc_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [256];

    always #5 clk = ~clk;

    // Synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    instr_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .ir_out    (ir_out),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .exec_done (exec_done),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .halt      (halt),
        .data_req  (data_req),
        .data_addr (data_addr),
        .pc_out    (pc_out)
    );

    typedef struct {
        logic        rdy;
        logic        done;
        logic        load;
        logic        hlt;
        logic        dreq;
        logic [7:0]  tgt;
        logic [7:0]  daddr;
        logic        e_iv;
        logic        e_rd;
        logic [7:0]  e_addr;
        logic [15:0] e_ir;
        logic [7:0]  e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rdy, input logic done, input logic load, input logic hlt,
                       input logic dreq, input logic [7:0] tgt, input logic [7:0] daddr,
                       input logic iv, input logic rd, input logic [7:0] addr,
                       input logic [15:0] ir, input logic [7:0] pc);
        vec_t t;
        t.rdy = rdy; t.done = done; t.load = load; t.hlt = hlt; t.dreq = dreq;
        t.tgt = tgt; t.daddr = daddr;
        t.e_iv = iv; t.e_rd = rd; t.e_addr = addr; t.e_ir = ir; t.e_pc = pc;
        vecs.push_back(t);
    endtask

    task automatic chk(input string tag, input string field, input logic [15:0] got,
                       input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s %s: got %h expected %h", tag, field, got, exp);
        end
    endtask

    task automatic exp_outs(input string tag, input logic iv, input logic rd,
                            input logic [7:0] addr, input logic [15:0] ir, input logic [7:0] pc);
        chk(tag, "ir_valid", {15'd0, ir_valid}, {15'd0, iv});
        chk(tag, "mem_rd",   {15'd0, mem_rd},   {15'd0, rd});
        chk(tag, "mem_addr", {8'd0, mem_addr},  {8'd0, addr});
        chk(tag, "ir_out",   ir_out,            ir);
        chk(tag, "pc_out",   {8'd0, pc_out},    {8'd0, pc});
    endtask

    task automatic drive(input logic rdy, input logic done, input logic load, input logic hlt,
                         input logic dreq, input logic [7:0] tgt, input logic [7:0] daddr);
        ir_ready = rdy; exec_done = done; pc_load = load; halt = hlt;
        data_req = dreq; pc_target = tgt; data_addr = daddr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]   = 16'hD105;
        mem[1]   = 16'hD2FF;
        mem[2]   = 16'hA0C1;
        mem[255] = 16'h1234;
        mem_rdata = 16'h0000;

        //  rdy dn ld ht dq tgt    daddr  | iv rd addr   ir        pc
        add(0, 0, 0, 0, 0, 8'h00, 8'h00,   0, 0, 8'h00, 16'h0000, 8'h00); // RST
        add(0, 0, 0, 0, 0, 8'h00, 8'h00,   0, 1, 8'h00, 16'h0000, 8'h00); // ADDR
        add(0, 0, 0, 0, 0, 8'h00, 8'h00,   0, 1, 8'h00, 16'h0000, 8'h00); // WAIT
        for (int i = 0; i < 5; i++)                                          // VALID held
            add(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 16'hD105, 8'h01);
        add(1, 0, 0, 0, 0, 8'h00, 8'h00,   1, 0, 8'h01, 16'hD105, 8'h01); // accept
        add(0, 0, 0, 0, 1, 8'h00, 8'h40,   0, 0, 8'h40, 16'hD105, 8'h01); // EXEC data_req
        add(0, 0, 0, 0, 0, 8'h00, 8'h40,   0, 0, 8'h01, 16'hD105, 8'h01); // drop data_req
        add(0, 1, 0, 0, 0, 8'h00, 8'h00,   0, 0, 8'h01, 16'hD105, 8'h01); // exec_done
        add(0, 0, 0, 0, 0, 8'h00, 8'h00,   0, 1, 8'h01, 16'hD105, 8'h01); // ADDR
        add(0, 1, 1, 1, 1, 8'h77, 8'h55,   0, 1, 8'h01, 16'hD105, 8'h01); // WAIT, ignored ctl
        add(1, 0, 0, 0, 0, 8'h00, 8'h00,   1, 0, 8'h02, 16'hD2FF, 8'h02); // VALID, no bubble
        add(0, 1, 1, 0, 0, 8'hFF, 8'h00,   0, 0, 8'h02, 16'hD2FF, 8'h02); // jump to FF
        add(0, 0, 0, 0, 0, 8'h00, 8'h00,   0, 1, 8'hFF, 16'hD2FF, 8'hFF); // ADDR
        add(0, 0, 0, 0, 0, 8'h00, 8'h00,   0, 1, 8'hFF, 16'hD2FF, 8'hFF); // WAIT
        add(1, 0, 0, 0, 0, 8'h00, 8'h00,   1, 0, 8'h00, 16'h1234, 8'h00); // wrapped PC
        add(0, 1, 0, 0, 0, 8'h00, 8'h00,   0, 0, 8'h00, 16'h1234, 8'h00); // exec_done
        add(0, 0, 0, 0, 0, 8'h00, 8'h00,   0, 1, 8'h00, 16'h1234, 8'h00); // ADDR mem[0]
        add(0, 0, 0, 0, 0, 8'h00, 8'h00,   0, 1, 8'h00, 16'h1234, 8'h00); // WAIT
        add(1, 0, 0, 0, 0, 8'h00, 8'h00,   1, 0, 8'h01, 16'hD105, 8'h01); // VALID
        add(0, 1, 1, 1, 0, 8'h02, 8'h00,   0, 0, 8'h01, 16'hD105, 8'h01); // load+halt

        drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
        reset = 1'b1;
        tick();
        tick();
        exp_outs("reset", 0, 0, 8'h00, 16'h0000, 8'h00);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].rdy, vecs[i].done, vecs[i].load, vecs[i].hlt, vecs[i].dreq,
                  vecs[i].tgt, vecs[i].daddr);
            #1;
            exp_outs($sformatf("vec%0d", i), vecs[i].e_iv, vecs[i].e_rd, vecs[i].e_addr,
                     vecs[i].e_ir, vecs[i].e_pc);
            tick();
        end

        // Halted: everything frozen even with control inputs toggling.
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, 0, 0, 8'h99, 8'h00);
            #1;
            exp_outs($sformatf("halt%0d", i), 0, 0, 8'h02, 16'hD105, 8'h02);
            tick();
        end

        // Reset out of halt, then reset again in the middle of a fetch.
        drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
        reset = 1'b1;
        tick();
        exp_outs("rst_from_halt", 0, 0, 8'h00, 16'h0000, 8'h00);
        reset = 1'b0;
        tick();
        tick();
        exp_outs("pre_wait", 0, 1, 8'h00, 16'h0000, 8'h00);
        reset = 1'b1;
        tick();
        exp_outs("rst_in_wait", 0, 0, 8'h00, 16'h0000, 8'h00);
        reset = 1'b0;
        tick();
        exp_outs("refetch_addr", 0, 1, 8'h00, 16'h0000, 8'h00);
        tick();
        tick();
        exp_outs("refetch_valid", 1, 0, 8'h01, 16'hD105, 8'h01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
